frog_game_ctrl: RTL
===================

# frog_game_ctrl

Frame-rate game sequencer for the Frogger datapath. Samples the per-pixel frog/car collision flag and the frog's vertical position once per video frame. Runs the play / death / win / game-over state machine, tracks lives and score, and drives freeze, respawn and red-flash controls back into the frog/car motion blocks and the color mapper. Sits between the VGA controller (`frame_clk`), the sprite blocks and the color mapper.

## Interface
- `LIVES`, 3: lives loaded at game start (1..7)
- `DEATH_FRAMES`, 60: frames spent in DEATH before respawn/game-over (≥2)
- `FLASH_PERIOD`, 8: frames per half-period of the death flash
- `GOAL_Y`, 40: frog top-edge Y at or above which (`frog_y <= GOAL_Y`) the crossing scores
- `WIN_SCORE`, 5: score that ends the game in WIN
- `Clk` input 1: system clock (50 MHz)
- `Reset_n` input 1: reset; one clock domain, asynchronous, active-low
- `frame_clk` input 1: VGA vertical sync, asynchronous to `Clk`
- `collision` input 1: high on any pixel where a frog and a car overlap
- `frog_y` input 10: frog top-edge Y, stable during each frame
- `start` input 1: player start key, active-high level
- `state` output 3: IDLE=0, PLAY=1, DEATH=2, WIN=3, GAMEOVER=4
- `lives` output 3: remaining lives
- `score` output 8: successful crossings
- `freeze` output 1: high means motion blocks hold position
- `respawn` output 1: one-`Clk` pulse; frog returns to its start position
- `flash_red` output 1: high means the color mapper paints the frog red

## Operation
- **Reset values:** `state`=IDLE, `lives`=`LIVES`, `score`=0, `freeze`=1, `respawn`=0, `flash_red`=0. Frame counter, hit latch and sync flops are all 0.
- **Frame tick:** `frame_clk` passes through a 2-flop synchronizer. `tick` is a one-`Clk` pulse on the synchronized rising edge.
- **Hit latch:** in PLAY, `collision`=1 sets a sticky `hit`. On the `tick` cycle the evaluated hit is `hit | collision`, and `hit` clears the same cycle. Outside PLAY, `hit` is held at 0.
- **IDLE:**
  - `freeze`=1.
  - `start`=1 → load `lives`=`LIVES` and `score`=0, pulse `respawn`, go to PLAY.
- **PLAY:** `freeze`=0. On `tick`:
  - If evaluated hit → DEATH and clear the frame counter. Collision has priority over goal in the same frame.
  - Else if `frog_y <= GOAL_Y` → `score`+1 and pulse `respawn`.
    - If the new score equals `WIN_SCORE` → WIN.
    - Otherwise stay in PLAY.
  - `collision` and `frog_y` between ticks affect only the latch.
- **DEATH:**
  - `freeze`=1.
  - Frame counter increments on each `tick`.
  - `flash_red` = bit `log2(FLASH_PERIOD)` of the counter. `FLASH_PERIOD` must be a power of 2. The counter is 0 on entry, so `flash_red` starts at 0 for the first `FLASH_PERIOD` frames.
  - On the `tick` where the counter reaches `DEATH_FRAMES`-1:
    - If `lives`==1 → `lives`=0, go to GAMEOVER.
    - Else `lives`-1, pulse `respawn`, go to PLAY.
  - `flash_red` is forced to 0 on exit.
- **WIN / GAMEOVER:**
  - `freeze`=1; `lives` and `score` hold.
  - `start`=1 → same action as from IDLE.
- **Score arithmetic:** saturates at 255. `lives` never underflows.
- **Invalid state encoding** → IDLE on next `Clk`.
- **`start` handling:** ignored in PLAY and DEATH. It is level-sensitive, so a held key restarts only from IDLE/WIN/GAMEOVER.

## Timing
- `tick` asserts 3 `Clk` after the `frame_clk` rising edge: 2 sync flops plus the edge register.
- Transitions and counter/score/lives updates are registered on the `Clk` edge at the end of the `tick` cycle.
- All outputs are registered, with no combinational input-to-output path.
- `respawn` is high exactly 1 `Clk`, in the cycle after the qualifying `tick` or `start`.
- `freeze` changes with `state` on the same edge.
- `Reset_n` low at any time, including mid-DEATH, forces all reset values immediately. Operation resumes on the first `Clk` after release, with `tick` suppressed until a fresh edge has passed through the synchronizer.

## Test plan
- **Reset and start:** `Reset_n`=0, then 1; hold `start`=1 for 1 `Clk` → `state`=PLAY, `lives`=3, `score`=0, `freeze`=0, one `respawn` pulse.
- **Collision, lives remaining:** in PLAY, pulse `collision` for 1 `Clk` mid-frame → DEATH at next `tick`.
  - `flash_red` is 0 for frames 0–7, 1 for frames 8–15, and so on.
  - After 60 ticks: `lives`=2, `respawn` pulse, `state`=PLAY.
- **Collision, last life:** with `lives`=1, collision → DEATH; after 60 ticks `state`=GAMEOVER, `lives`=0, `freeze`=1. `start` → PLAY, `lives`=3.
- **Goal crossings to WIN:** set `frog_y`=30 (≤ 40) across 5 ticks, no collision → `score` goes 1..5 with a `respawn` each tick, then `state`=WIN.
- **Simultaneous events:** `frog_y`=30 and `collision`=1 asserted on the same `tick` cycle → DEATH, `score` unchanged.
- **Async events:** assert `Reset_n`=0 mid-DEATH at frame 20 → immediate IDLE, `flash_red`=0, `lives`=3. Also drive `frame_clk` asynchronously with a jittered period → exactly one `tick` per `frame_clk` rising edge.

Source files
------------

// File: rtl/frog_game_if.sv
`timescale 1ns/1ps
// frog_game_if: frame-rate I/O bundle between the video/sprite side and the game sequencer.
// master drives frame_clk/collision/frog_y/start; slave (the sequencer) drives state/lives/score/freeze/respawn/flash_red.
interface frog_game_if;
   logic       frame_clk;
   logic       collision;
   logic [9:0] frog_y;
   logic       start;
   logic [2:0] state;
   logic [2:0] lives;
   logic [7:0] score;
   logic       freeze;
   logic       respawn;
   logic       flash_red;

   modport master (
      output frame_clk, collision, frog_y, start,
      input  state, lives, score, freeze, respawn, flash_red
   );

   modport slave (
      input  frame_clk, collision, frog_y, start,
      output state, lives, score, freeze, respawn, flash_red
   );
endinterface

// File: rtl/frog_game_ctrl.sv
`timescale 1ns/1ps
// frog_game_ctrl: Frogger play/death/win/game-over sequencer, stepped once per video frame.
// Ports: Clk, Reset_n (async, active-low), bus (frog_game_if.slave: frame/collision/frog_y/start in, status/controls out).
module frog_game_ctrl #(
   parameter int LIVES        = 3,
   parameter int DEATH_FRAMES = 60,
   parameter int FLASH_PERIOD = 8,
   parameter int GOAL_Y       = 40,
   parameter int WIN_SCORE    = 5
) (
   input  logic        Clk,
   input  logic        Reset_n,
   frog_game_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PLAY  = 3'd1,
      DEATH = 3'd2,
      WIN   = 3'd3,
      OVER  = 3'd4
   } st_t;

   localparam int CW = 16;
   localparam int FB = $clog2(FLASH_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(DEATH_FRAMES - 1);
   localparam logic [9:0]    GY   = 10'(GOAL_Y);
   localparam logic [7:0]    WS   = 8'(WIN_SCORE);
   localparam logic [2:0]    LV   = 3'(LIVES);

   st_t           st;
   logic [2:0]    lives;
   logic [7:0]    score;
   logic          freeze;
   logic          respawn;
   logic          flash;
   logic          hit;
   logic [CW-1:0] cnt;

   logic          s1, s2, s3;
   logic          tick;
   logic [7:0]    score_inc;
   logic [CW-1:0] cnt_inc;
   logic          hit_eval;

   // s1/s2 resynchronise vsync; s3 holds the previous sample so the
   // rising edge becomes a single registered tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         tick <= 1'b0;
      end else begin
         s1   <= bus.frame_clk;
         s2   <= s1;
         s3   <= s2;
         tick <= s2 & ~s3;
      end
   end

   assign score_inc = (score == 8'hff) ? score : score + 8'd1;
   assign cnt_inc   = cnt + CW'(1);
   // A collision seen on the tick cycle itself still counts.
   assign hit_eval  = hit | bus.collision;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         st      <= IDLE;
         lives   <= LV;
         score   <= 8'd0;
         freeze  <= 1'b1;
         respawn <= 1'b0;
         flash   <= 1'b0;
         hit     <= 1'b0;
         cnt     <= '0;
      end else begin
         respawn <= 1'b0;
         case (st)
            IDLE, WIN, OVER: begin
               hit   <= 1'b0;
               flash <= 1'b0;
               if (bus.start) begin
                  lives   <= LV;
                  score   <= 8'd0;
                  respawn <= 1'b1;
                  freeze  <= 1'b0;
                  st      <= PLAY;
               end
            end
            PLAY: begin
               if (tick) begin
                  hit <= 1'b0;
                  if (hit_eval) begin
                     st     <= DEATH;
                     freeze <= 1'b1;
                     cnt    <= '0;
                     flash  <= 1'b0;
                  end else if (bus.frog_y <= GY) begin
                     score   <= score_inc;
                     respawn <= 1'b1;
                     if (score_inc == WS) begin
                        st     <= WIN;
                        freeze <= 1'b1;
                     end
                  end
               end else begin
                  hit <= hit_eval;
               end
            end
            DEATH: begin
               hit <= 1'b0;
               if (tick) begin
                  if (cnt == LAST) begin
                     flash <= 1'b0;
                     if (lives <= 3'd1) begin
                        lives  <= 3'd0;
                        st     <= OVER;
                        freeze <= 1'b1;
                     end else begin
                        lives   <= lives - 3'd1;
                        respawn <= 1'b1;
                        freeze  <= 1'b0;
                        st      <= PLAY;
                     end
                  end else begin
                     cnt   <= cnt_inc;
                     flash <= cnt_inc[FB];
                  end
               end
            end
            default: begin
               st     <= IDLE;
               freeze <= 1'b1;
               flash  <= 1'b0;
               hit    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state     = st;
   assign bus.lives     = lives;
   assign bus.score     = score;
   assign bus.freeze    = freeze;
   assign bus.respawn   = respawn;
   assign bus.flash_red = flash;

endmodule
